seq_det_sched: RTL and testbench

Round-robin scheduler that shares one serial repeated-bit pattern detector among NUM_CH requesters. The block grants one requester at a time and latches that requester's parallel word. It then shifts the word MSB-first through an internal 4-state Moore detector, counting every adjacent equal-bit pair ("11" or "00"). It returns the hit count to the granted channel with a one-cycle done pulse. It sits between the per-channel word sources and the result collector in the serial detection path.

---
 rtl/seq_det_sched.sv | 171 +++++++++++++++++
 tb/tb_seq_det_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial repeated-bit detector among NUM_CH requesters.
// Each granted word is shifted MSB-first and every adjacent equal-bit pair is counted.
module seq_det_sched #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_W   = $clog2(NUM_CH),
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        gnt,
  output logic                     busy,
  output logic                     done,
  output logic [CH_W-1:0]          done_ch,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic                     match_any
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StReport = 2'd2;

  localparam logic [1:0] DetS0 = 2'd0;
  localparam logic [1:0] DetS1 = 2'd1;
  localparam logic [1:0] DetS2 = 2'd2;
  localparam logic [1:0] DetS3 = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   done_ch_q, done_ch_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic              match_any_q, match_any_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [1:0]        det_q, det_d;
  logic              last_bit_q, last_bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;

  logic              win_found;
  logic [CH_W-1:0]   win_ch;
  logic [CH_W-1:0]   cand;
  logic              bit_in;
  logic [1:0]        det_nx;
  logic [CNT_W-1:0]  cnt_nx;

  // Search upward from the channel after the last one served, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((32'(last_grant_q) + k) % NUM_CH);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_ch    = cand;
      end
    end
  end

  // S3 remembers the bit that produced it so runs keep counting every pair.
  always_comb begin
    bit_in = shreg_q[DATA_W-1];
    case (det_q)
      DetS0:   det_nx = bit_in ? DetS1 : DetS2;
      DetS1:   det_nx = bit_in ? DetS3 : DetS2;
      DetS2:   det_nx = bit_in ? DetS1 : DetS3;
      default: det_nx = (bit_in == last_bit_q) ? DetS3 : (bit_in ? DetS1 : DetS2);
    endcase
    cnt_nx = cnt_q + CNT_W'(det_nx == DetS3);
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = '0;
    busy_d       = busy_q;
    done_d       = done_q;
    done_ch_d    = done_ch_q;
    hit_cnt_d    = hit_cnt_q;
    match_any_d  = match_any_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    det_d        = det_q;
    last_bit_d   = last_bit_q;
    cnt_d        = cnt_q;
    cur_ch_d     = cur_ch_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d     = NUM_CH'(1) << win_ch;
          busy_d    = 1'b1;
          cur_ch_d  = win_ch;
          shreg_d   = data[32'(win_ch)*DATA_W +: DATA_W];
          bit_idx_d = '0;
          det_d     = DetS0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        shreg_d    = {shreg_q[DATA_W-2:0], 1'b0};
        det_d      = det_nx;
        last_bit_d = bit_in;
        cnt_d      = cnt_nx;
        bit_idx_d  = bit_idx_q + CNT_W'(1);
        if (bit_idx_q == CNT_W'(DATA_W-1)) begin
          hit_cnt_d    = cnt_nx;
          match_any_d  = (cnt_nx != '0);
          done_ch_d    = cur_ch_q;
          done_d       = 1'b1;
          last_grant_d = cur_ch_q;
          state_d      = StReport;
        end
      end
      StReport: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_ch_q    <= '0;
      hit_cnt_q    <= '0;
      match_any_q  <= 1'b0;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      det_q        <= DetS0;
      last_bit_q   <= 1'b0;
      cnt_q        <= '0;
      cur_ch_q     <= '0;
      last_grant_q <= CH_W'(NUM_CH-1);
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_ch_q    <= done_ch_d;
      hit_cnt_q    <= hit_cnt_d;
      match_any_q  <= match_any_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      det_q        <= det_d;
      last_bit_q   <= last_bit_d;
      cnt_q        <= cnt_d;
      cur_ch_q     <= cur_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_ch   = done_ch_q;
  assign hit_cnt   = hit_cnt_q;
  assign match_any = match_any_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: a driver predicts grants and counts from a
// round-robin/pair-count model, a monitor checks whatever the DUT presents.
module tb_seq_det_sched;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 3;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH-1:0]        gnt;
  logic                     busy;
  logic                     done;
  logic [CH_W-1:0]          done_ch;
  logic [CNT_W-1:0]         hit_cnt;
  logic                     match_any;

  seq_det_sched #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .done_ch  (done_ch),
    .hit_cnt  (hit_cnt),
    .match_any(match_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int cnt;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   gq[$];
  res_t dq[$];

  logic [DATA_W-1:0] dat[NUM_CH];
  logic [NUM_CH-1:0] pending;
  int                m_last;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pairs(input logic [DATA_W-1:0] w);
    int c = 0;
    for (int i = 0; i < DATA_W - 1; i++) if (w[i] == w[i+1]) c++;
    return c;
  endfunction

  function automatic int pick(input logic [NUM_CH-1:0] m, input int last);
    for (int k = 1; k <= NUM_CH; k++) if (m[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  task automatic drive(input logic [NUM_CH-1:0] r);
    req = r;
    for (int i = 0; i < NUM_CH; i++) data[i*DATA_W +: DATA_W] = dat[i];
  endtask

  // Called just after an edge, with the next edge being an idle (arbitration) edge.
  task automatic run_txn(input logic [NUM_CH-1:0] add, input logic [NUM_CH-1:0] glitch);
    int   w;
    res_t r;
    pending = pending | add;
    drive(pending);
    w = pick(pending, m_last);
    if (w < 0) begin
      @(posedge clk); #1;
      return;
    end
    gq.push_back(w);
    r.ch  = w;
    r.cnt = pairs(dat[w]);
    dq.push_back(r);
    @(posedge clk); #1;
    pending[w] = 1'b0;
    m_last     = w;
    drive(pending);
    for (int e = 1; e <= DATA_W + 1; e++) begin
      @(posedge clk); #1;
      if (e == 5) drive(pending | glitch);
      if (e == 8) drive(pending);
    end
  endtask

  // Monitor: compares gnt/busy/done timing and result payloads.
  initial begin
    int   since   = -1;
    bit   was_rst = 1'b1;
    int   e;
    res_t r;
    forever begin
      @(negedge clk);
      if (was_rst) begin
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit_cnt", int'(hit_cnt), 0);
        chk("rst_match_any", int'(match_any), 0);
        chk("rst_done_ch", int'(done_ch), 0);
        since = -1;
      end else begin
        if (gnt != '0) begin
          if (gq.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
          else begin
            e = gq.pop_front();
            chk("gnt_onehot", int'(gnt), 1 << e);
          end
          since = 0;
        end else if (since >= 0) since++;
        chk("busy", int'(busy), int'(since >= 0));
        chk("done_timing", int'(done), int'(since == DATA_W));
        if (done) begin
          if (dq.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            r = dq.pop_front();
            chk("done_ch", int'(done_ch), r.ch);
            chk("hit_cnt", int'(hit_cnt), r.cnt);
            chk("match_any", int'(match_any), int'(r.cnt != 0));
          end
        end
        if (since == DATA_W) since = -1;
      end
      was_rst = rst;
    end
  end

  initial begin
    res_t r;
    logic [DATA_W-1:0] ch2_words[4];
    ch2_words[0] = 8'hAA;
    ch2_words[1] = 8'hFF;
    ch2_words[2] = 8'h00;
    ch2_words[3] = 8'h0F;
    for (int i = 0; i < NUM_CH; i++) dat[i] = DATA_W'(8'h11 * (i + 3));
    pending = '0;
    m_last  = NUM_CH - 1;
    rst     = 1'b1;
    drive(4'hF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All four held after reset: served 0,1,2,3, each with its own word.
    pending = 4'hF;
    for (int i = 0; i < NUM_CH; i++) run_txn('0, '0);

    dat[0] = 8'hCC;
    run_txn(4'b0001, '0);
    for (int i = 0; i < 4; i++) begin
      dat[2] = ch2_words[i];
      run_txn(4'b0100, '0);
    end

    // Reset after three shift edges of a ch1 transaction.
    dat[1] = 8'h5A;
    pending = 4'b0010;
    drive(pending);
    gq.push_back(pick(pending, m_last));
    @(posedge clk); #1;
    pending = '0;
    drive(pending);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    m_last = NUM_CH - 1;
    repeat (DATA_W + 3) @(posedge clk);
    #1;
    run_txn(4'b0011, '0);
    run_txn('0, '0);

    // ch3 pulses and drops while ch1 is busy; it must never be granted.
    dat[1] = 8'h3C;
    run_txn(4'b0010, 4'b1000);
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [NUM_CH-1:0] add;
      add = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      if ($urandom_range(0, 3) == 0) add = '0;
      for (int i = 0; i < NUM_CH; i++)
        if (add[i] && !pending[i]) dat[i] = DATA_W'($urandom);
      run_txn(add, '0);
    end
    while (pending != '0) run_txn('0, '0);

    for (int i = 0; i < 200 && (gq.size() != 0 || dq.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("queues_drained", gq.size() + dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
